// File: rtl/snn_syn_pkg.sv
// ============================================================================
//  Module   : snn_syn_pkg
//  Purpose  : Shared types, default widths and arithmetic helpers for the
//             synapse accumulator (FSM state enum, saturating add, 16-bit
//             unsigned output clamp).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package snn_syn_pkg;

  typedef enum logic [0:0] {
    ACCUM  = 1'b0,
    UPDATE = 1'b1
  } syn_state_t;

  localparam int DEF_N_SYN     = 16;
  localparam int DEF_ACC_W     = 24;
  localparam int DEF_TAU_SHIFT = 3;
  localparam int WEIGHT_W      = 16;
  localparam int CUR_W         = 16;

  // All intermediate arithmetic is done at this width so that a sum of two
  // in-range ACC_W values can never wrap before it is saturated.
  localparam int CALC_W        = 64;

  // Signed add saturated to the range of a signed 'width'-bit value.
  function automatic logic signed [CALC_W-1:0] sat_add(
    input logic signed [CALC_W-1:0] a,
    input logic signed [CALC_W-1:0] b,
    input int                       width
  );
    logic signed [CALC_W-1:0] sum;
    logic signed [CALC_W-1:0] max_v;
    logic signed [CALC_W-1:0] min_v;
    sum   = a + b;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (sum > max_v) begin
      return max_v;
    end else if (sum < min_v) begin
      return min_v;
    end else begin
      return sum;
    end
  endfunction

  // Negative values clamp to 0, anything above 16 bits clamps to all-ones.
  function automatic logic [CUR_W-1:0] clamp16(input logic signed [CALC_W-1:0] v);
    if (v < 64'sd0) begin
      return '0;
    end else if (v > 64'sd65535) begin
      return 16'hFFFF;
    end else begin
      return v[CUR_W-1:0];
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/syn_weight_rf.sv
// ============================================================================
//  Module   : syn_weight_rf
//  Purpose  : N_SYN x DATA_W weight register file, one asynchronous read
//             port and one synchronous write port, synchronous reset to 0.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             we, wr_addr, wr_data - write port (applied at rising edge)
//             rd_addr, rd_data    - combinational read port; a read in the
//                                   same cycle as a write to the same entry
//                                   returns the old contents
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module syn_weight_rf #(
  parameter int N_SYN  = 16,
  parameter int ADDR_W = $clog2(N_SYN),
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] regs [N_SYN];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_SYN; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data = regs[rd_addr];

endmodule

`default_nettype wire

// File: rtl/synapse_accumulator.sv
// ============================================================================
//  Module   : synapse_accumulator
//  Purpose  : Accepts address-event spikes, looks up a signed per-synapse
//             weight, sums weighted spikes over one timestep and on each
//             timestep strobe emits a clamped 16-bit unsigned current.
//             Optional build macro SYN_DECAY_EN adds a persistent
//             exponentially decaying synaptic trace:
//               trace = sat(trace - (trace >>> TAU_SHIFT) + acc)
//  Ports    : clk, reset           - clock, synchronous active-high reset
//             ev_valid/ev_addr/ev_ready - spike event stream
//             w_we/w_addr/w_data   - weight write port (any state)
//             step                 - timestep strobe
//             current_out          - clamped synaptic current (held)
//             current_valid        - one-cycle pulse on each update
//             step_overrun         - sticky: step seen during UPDATE
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module synapse_accumulator
  import snn_syn_pkg::*;
#(
  parameter int N_SYN     = DEF_N_SYN,
  parameter int ADDR_W    = $clog2(N_SYN),
  parameter int ACC_W     = DEF_ACC_W,
  parameter int TAU_SHIFT = DEF_TAU_SHIFT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ev_valid,
  input  logic [ADDR_W-1:0] ev_addr,
  output logic              ev_ready,
  input  logic              w_we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [15:0]       w_data,
  input  logic              step,
  output logic [15:0]       current_out,
  output logic              current_valid,
  output logic              step_overrun
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if ((N_SYN < 2) || ((N_SYN & (N_SYN - 1)) != 0)) begin : g_chk_nsyn
    $error("synapse_accumulator: N_SYN must be a power of two >= 2");
  end
  if ((ACC_W < 18) || (ACC_W > 62)) begin : g_chk_accw
    $error("synapse_accumulator: ACC_W must be in 18..62");
  end
  if ((TAU_SHIFT < 1) || (TAU_SHIFT > ACC_W - 2)) begin : g_chk_tau
    $error("synapse_accumulator: TAU_SHIFT must be in 1..ACC_W-2");
  end

  // --------------------------------------------------------------------------
  // Weight storage
  // --------------------------------------------------------------------------
  logic [WEIGHT_W-1:0] weight;

  syn_weight_rf #(
    .N_SYN  (N_SYN),
    .ADDR_W (ADDR_W),
    .DATA_W (WEIGHT_W)
  ) u_weight_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (w_we),
    .wr_addr (w_addr),
    .wr_data (w_data),
    .rd_addr (ev_addr),
    .rd_data (weight)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  syn_state_t state;
  syn_state_t state_next;

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (step) state_next = UPDATE;
      UPDATE:  state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Held low while reset is asserted so no event is handshaken in the reset
  // cycle even though the state register already reads ACCUM.
  assign ev_ready = (state == ACCUM) && !reset;

  logic ev_accept;
  assign ev_accept = ev_valid && ev_ready;

  // --------------------------------------------------------------------------
  // Accumulator datapath
  // --------------------------------------------------------------------------
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_add;
  logic signed [CALC_W-1:0] acc_ext;
  logic signed [CALC_W-1:0] weight_ext;
  logic [CUR_W-1:0]         current_next;

  assign acc_ext    = {{(CALC_W - ACC_W){acc[ACC_W-1]}}, acc};
  assign weight_ext = {{(CALC_W - WEIGHT_W){weight[WEIGHT_W-1]}}, weight};
  assign acc_add    = ACC_W'(sat_add(acc_ext, weight_ext, ACC_W));

`ifdef SYN_DECAY_EN
  // Persistent trace: leaks by 2^-TAU_SHIFT per step, then absorbs this
  // step's accumulated input.
  logic signed [ACC_W-1:0]  trace;
  logic signed [ACC_W-1:0]  trace_next;
  logic signed [CALC_W-1:0] trace_ext;
  logic signed [CALC_W-1:0] trace_next_ext;

  assign trace_ext      = {{(CALC_W - ACC_W){trace[ACC_W-1]}}, trace};
  // trace - (trace >>> TAU_SHIFT) always stays inside the ACC_W range, so
  // only the final addition needs saturation.
  assign trace_next     = ACC_W'(sat_add(trace_ext - (trace_ext >>> TAU_SHIFT),
                                         acc_ext, ACC_W));
  assign trace_next_ext = {{(CALC_W - ACC_W){trace_next[ACC_W-1]}}, trace_next};
  assign current_next   = clamp16(trace_next_ext);

  always_ff @(posedge clk) begin
    if (reset) begin
      trace <= '0;
    end else if (state == UPDATE) begin
      trace <= trace_next;
    end
  end
`else
  // Without the trace every timestep is independent.
  assign current_next = clamp16(acc_ext);
`endif

  // --------------------------------------------------------------------------
  // State, accumulator and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ACCUM;
      acc           <= '0;
      current_out   <= '0;
      current_valid <= 1'b0;
      step_overrun  <= 1'b0;
    end else begin
      state         <= state_next;
      current_valid <= 1'b0;
      if (state == UPDATE) begin
        // ev_ready is low here, so no event can be lost by clearing acc.
        acc           <= '0;
        current_out   <= current_next;
        current_valid <= 1'b1;
        if (step) begin
          step_overrun <= 1'b1;
        end
      end else if (ev_accept) begin
        acc <= acc_add;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/synapse_accumulator.md
# synapse_accumulator

Upstream feeder for the LIF neuron: accepts address-event spikes on a valid/ready stream, looks up a per-synapse signed weight, and sums weighted spikes over one simulation timestep. On each timestep strobe it produces a clamped 16-bit unsigned synaptic current for the neuron's `input_current` input, with an optional exponentially decaying synaptic trace.

## Interface
- `N_SYN`, 16, synapse count; power of two, ≥2
- `ADDR_W`, $clog2(N_SYN), synapse address width (derived)
- `ACC_W`, 24, signed accumulator/trace width; ≥18
- `TAU_SHIFT`, 3, decay shift (used only with decay compiled in); 1..ACC_W-2
- Clock and reset: one clock, `clk`; reset is `reset`, synchronous, active-high.
- `clk` in 1: clock
- `reset` in 1: synchronous active-high reset
- `ev_valid` in 1: spike event present
- `ev_addr` in ADDR_W: spiking synapse index
- `ev_ready` out 1: event accepted when `ev_valid && ev_ready` at rising edge
- `w_we` in 1: weight write enable
- `w_addr` in ADDR_W: weight write index
- `w_data` in 16: signed weight
- `step` in 1: timestep strobe
- `current_out` out 16: unsigned synaptic current, drives neuron `input_current`
- `current_valid` out 1: one-cycle pulse when `current_out` updates
- `step_overrun` out 1: sticky; a `step` arrived while in UPDATE

## Operation
- FSM states: ACCUM, UPDATE. Reset → ACCUM.
- ACCUM: `ev_ready`=1. Each accepted event adds sign-extended `weight[ev_addr]` to `acc` (signed ACC_W), saturating at signed ACC_W min/max. `step`=1 → UPDATE.
- UPDATE (exactly one cycle): `ev_ready`=0; `step` ignored and sets `step_overrun`. At the closing edge: trace computed, `current_out` loaded, `current_valid`=1 for the next cycle, `acc` cleared to 0, → ACCUM.
- Event and `step` in the same ACCUM cycle: the event is included in this step's sum.
- Output clamp: trace <0 → 0; >65535 → 65535; else low 16 bits.
- Weights: N_SYN × 16-bit register file. Write at edge when `w_we`. A same-cycle event to `w_addr` uses the old weight (read-before-write). Writes are allowed in any state.
- Reset values: `current_out`=0, `current_valid`=0, `step_overrun`=0, `acc`=0, trace=0, all weights=0. `ev_ready`=0 in the reset cycle and 1 from the first ACCUM cycle.
- Reset mid-UPDATE: the update is discarded. No `current_valid` is produced.

## Timing
- `step` high at edge k (in ACCUM) → UPDATE during cycle k..k+1 → `current_out` valid and `current_valid`=1 in cycle after edge k+1 (2-cycle latency).
- Throughput: one event per cycle in ACCUM. One bubble cycle per timestep.
- Minimum `step` spacing: 2 cycles. A closer step sets `step_overrun` and is dropped.
- `current_out` holds its value between updates.

## Configuration
- `SYN_DECAY_EN` defined: persistent signed trace, updated in UPDATE as `trace = trace - (trace >>> TAU_SHIFT) + acc`, saturated to signed ACC_W. `current_out` = clamp(trace).
- Not defined: no trace register. `current_out` = clamp(acc), so each step is independent. `TAU_SHIFT` is unused.

## Structure
- Package `snn_syn_pkg`: state enum (ACCUM, UPDATE), default widths, and the saturating-add and 16-bit clamp functions.
- Sub-module `syn_weight_rf`: N_SYN × 16 register file with one async read port, one sync write port, and synchronous reset to 0.
- Top level holds the FSM, accumulator, trace and output registers.

## Test plan
- Reset; write w[3]=100; 5 events to addr 3; `step` → `current_valid` one pulse 2 cycles later, `current_out`=500. Next step with no events → 0 (decay off).
- w[1]=-300, w[2]=200; events 2,1 → `current_out`=0 (negative clamp). w[0]=0x7FFF; 4 events → `current_out`=65535.
- Event to addr 5 in the same cycle as `step` → included. `step` on two consecutive cycles → second dropped, `step_overrun`=1, `ev_ready`=0 during UPDATE.
- Same-cycle `w_we` to addr 4 (old 10, new 50) plus event addr 4 → sum 10; a later event uses 50.
- `SYN_DECAY_EN`, `TAU_SHIFT`=3: 8 events of weight 100, step → 800; next empty step → 700; next → 613.
- Assert `reset` during UPDATE → no `current_valid`, `current_out`=0, weights 0, `step_overrun` cleared.
